// File: rtl/matvec_pkg.sv
// Shared sizes and state encoding for the matrix-vector coprocessor sequencer.
// A is 64x8, B is 8x1 and RES is 64x1, all with 8-bit words.
package matvec_pkg;
  localparam int A_DEPTH_BITS   = 9;
  localparam int B_DEPTH_BITS   = 3;
  localparam int RES_DEPTH_BITS = 6;
  localparam int A_WORDS        = 1 << A_DEPTH_BITS;
  localparam int B_WORDS        = 1 << B_DEPTH_BITS;
  localparam int RES_WORDS      = 1 << RES_DEPTH_BITS;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX_A     = 3'd1,
    ST_RX_B     = 3'd2,
    ST_COMP     = 3'd3,
    ST_TX_PRIME = 3'd4,
    ST_TX       = 3'd5
  } state_t;
endpackage

// File: rtl/matvec_idx_cnt.sv
// Row-major {row,col} index counter with column and full-range wrap flags.
// Shared by the A-matrix fill and the COMP issue sequence.
module matvec_idx_cnt #(
  parameter int ROW_BITS = 6,
  parameter int COL_BITS = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clr,
  input  logic                         i_inc,
  output logic [ROW_BITS+COL_BITS-1:0] o_idx,
  output logic [ROW_BITS-1:0]          o_row,
  output logic [COL_BITS-1:0]          o_col,
  output logic                         o_col_last,
  output logic                         o_idx_last
);
  logic [ROW_BITS-1:0] r_row;
  logic [COL_BITS-1:0] r_col;

  assign o_row      = r_row;
  assign o_col      = r_col;
  assign o_idx      = {r_row, r_col};
  assign o_col_last = &r_col;
  assign o_idx_last = (&r_col) & (&r_row);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_inc) begin
      r_col <= r_col + 1'b1;
      if (o_col_last) r_row <= r_row + 1'b1;
    end
  end
endmodule

// File: rtl/matvec_seq_ctrl.sv
// Control sequencer for the AXIS matrix-vector coprocessor: receives A then B,
// runs the MAC sweep over the external RAMs, then streams RES out.
module matvec_seq_ctrl
  import matvec_pkg::*;
(
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      S_AXIS_TVALID,
  input  logic                      S_AXIS_TLAST,
  output logic                      S_AXIS_TREADY,
  input  logic                      M_AXIS_TREADY,
  output logic                      M_AXIS_TVALID,
  output logic                      M_AXIS_TLAST,
  output logic [A_DEPTH_BITS-1:0]   a_addr,
  output logic                      a_wen,
  output logic [B_DEPTH_BITS-1:0]   b_addr,
  output logic                      b_wen,
  output logic [RES_DEPTH_BITS-1:0] res_addr,
  output logic                      res_wen,
  output logic                      res_ren,
  output logic                      mac_en,
  output logic                      mac_first,
  output logic                      frame_done,
  output logic [2:0]                o_dbg_state
);
  // Valid/ready: a beat transfers on a rising edge where both valid and ready
  // are 1; the master holds valid and its data steady until that edge.
  state_t                    r_state, w_state_nxt;
  logic                      w_leave, w_issue, w_beat_out;
  logic [A_DEPTH_BITS-1:0]   w_idx;
  logic [RES_DEPTH_BITS-1:0] w_row;
  logic [B_DEPTH_BITS-1:0]   w_col;
  logic                      w_col_last, w_idx_last;
  logic [B_DEPTH_BITS-1:0]   r_b_cnt;
  logic [RES_DEPTH_BITS-1:0] r_tx_cnt;
  logic                      r_issue_done;
  logic                      r_p1_valid, r_p1_first, r_p1_wr, r_p2_wr;
  logic [RES_DEPTH_BITS-1:0] r_p1_row, r_p2_row;
  logic                      w_unused_tlast;

  // Framing is purely count-based, so TLAST on the input is not consumed.
  assign w_unused_tlast = S_AXIS_TLAST;
  assign o_dbg_state    = r_state;
  assign w_leave        = (w_state_nxt != r_state);
  assign w_issue        = (r_state == ST_COMP) & ~r_issue_done;
  assign w_beat_out     = M_AXIS_TVALID & M_AXIS_TREADY;

  matvec_idx_cnt #(
    .ROW_BITS (RES_DEPTH_BITS),
    .COL_BITS (B_DEPTH_BITS)
  ) u_idx (
    .i_clk      (ACLK),
    .i_rst_n    (ARESETN),
    .i_clr      (w_leave),
    .i_inc      (a_wen | w_issue),
    .o_idx      (w_idx),
    .o_row      (w_row),
    .o_col      (w_col),
    .o_col_last (w_col_last),
    .o_idx_last (w_idx_last)
  );

  always_comb begin
    w_state_nxt   = r_state;
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    a_addr        = '0;
    a_wen         = 1'b0;
    b_addr        = '0;
    b_wen         = 1'b0;
    res_addr      = '0;
    res_wen       = 1'b0;
    res_ren       = 1'b0;
    mac_en        = 1'b0;
    mac_first     = 1'b0;
    frame_done    = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_RX_A;
      ST_RX_A: begin
        S_AXIS_TREADY = 1'b1;
        a_addr        = w_idx;
        a_wen         = S_AXIS_TVALID;
        if (S_AXIS_TVALID && w_idx_last) w_state_nxt = ST_RX_B;
      end
      ST_RX_B: begin
        S_AXIS_TREADY = 1'b1;
        b_addr        = r_b_cnt;
        b_wen         = S_AXIS_TVALID;
        if (S_AXIS_TVALID && (&r_b_cnt)) w_state_nxt = ST_COMP;
      end
      ST_COMP: begin
        a_addr    = w_idx;
        b_addr    = w_col;
        mac_en    = r_p1_valid;
        mac_first = r_p1_valid & r_p1_first;
        res_wen   = r_p2_wr;
        res_addr  = r_p2_row;
        // The last row write drains the pipeline two cycles after the last issue.
        if (r_p2_wr && (&r_p2_row)) w_state_nxt = ST_TX_PRIME;
      end
      ST_TX_PRIME: begin
        res_ren     = 1'b1;
        w_state_nxt = ST_TX;
      end
      ST_TX: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TLAST  = &r_tx_cnt;
        res_addr      = r_tx_cnt;
        if (M_AXIS_TREADY) begin
          res_ren  = 1'b1;
          res_addr = r_tx_cnt + 1'b1;
          if (&r_tx_cnt) begin
            frame_done  = 1'b1;
            w_state_nxt = ST_RX_A;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state      <= ST_IDLE;
      r_b_cnt      <= '0;
      r_tx_cnt     <= '0;
      r_issue_done <= 1'b0;
      r_p1_valid   <= 1'b0;
      r_p1_first   <= 1'b0;
      r_p1_wr      <= 1'b0;
      r_p1_row     <= '0;
      r_p2_wr      <= 1'b0;
      r_p2_row     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_leave)     r_b_cnt <= '0;
      else if (b_wen)  r_b_cnt <= r_b_cnt + 1'b1;
      if (w_leave)         r_tx_cnt <= '0;
      else if (w_beat_out) r_tx_cnt <= r_tx_cnt + 1'b1;
      if (w_leave)                     r_issue_done <= 1'b0;
      else if (w_issue && w_idx_last)  r_issue_done <= 1'b1;
      r_p1_valid <= w_issue;
      r_p1_first <= (w_col == '0);
      r_p1_wr    <= w_issue & w_col_last;
      r_p1_row   <= w_row;
      r_p2_wr    <= r_p1_wr;
      r_p2_row   <= r_p1_row;
    end
  end
endmodule
